// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with registered status, log-coded fill flags,
// sticky overflow/underflow and an optional extra output register on DOUT.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 4,
    parameter int AE_LEVEL   = 4,
    parameter bit REG_RD     = 1'b0
) (
    input  logic                  Clk,
    input  logic                  Async_Flush,
    input  logic                  Clk_En,
    input  logic                  Fifo_Push_Flush,
    input  logic                  Fifo_Pop_Flush,
    input  logic                  PUSH,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  POP,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  Full,
    output logic                  Empty,
    output logic                  Almost_Full,
    output logic                  Almost_Empty,
    output logic [3:0]            PUSH_FLAG,
    output logic [3:0]            POP_FLAG,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Overflow,
    output logic                  Underflow
);

    localparam int                DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [3:0]          PUSH_FLAG_RST = 4'(ADDR_WIDTH + 1);

    // code(n): 0 for n==0, otherwise index of the highest set bit plus one
    function automatic logic [3:0] flag_code(input logic [ADDR_WIDTH:0] n);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i <= ADDR_WIDTH; i++) begin
            if (n[i]) c = 4'(i + 1);
        end
        return c;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  af_q, af_d, ae_q, ae_d;
    logic [3:0]            push_flag_q, push_flag_d, pop_flag_q, pop_flag_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;

    logic flush, push_ok, pop_ok, wr_en;

    assign flush   = Fifo_Push_Flush | Fifo_Pop_Flush;
    assign push_ok = PUSH & ~full_q;
    assign pop_ok  = POP & ~empty_q;
    assign wr_en   = Clk_En & ~flush & push_ok;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        rd_d    = rd_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (Clk_En) begin
            if (flush) begin
                wptr_d  = '0;
                rptr_d  = '0;
                count_d = '0;
                rd_d    = '0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
            end else begin
                if (push_ok) wptr_d = wptr_q + PTR_ONE;
                if (pop_ok) begin
                    rptr_d = rptr_q + PTR_ONE;
                    rd_d   = mem[rptr_q];
                end
                case ({push_ok, pop_ok})
                    2'b10:   count_d = count_q + CNT_ONE;
                    2'b01:   count_d = count_q - CNT_ONE;
                    default: count_d = count_q;
                endcase
                if (PUSH & full_q)  ovf_d = 1'b1;
                if (POP  & empty_q) unf_d = 1'b1;
            end
        end
        // Status is derived from the post-edge count so it moves with Count
        full_d      = (count_d == DEPTH_CNT);
        empty_d     = (count_d == '0);
        af_d        = (count_d >= AF_CNT);
        ae_d        = (count_d <= AE_CNT);
        pop_flag_d  = flag_code(count_d);
        push_flag_d = flag_code(DEPTH_CNT - count_d);
    end

    always_ff @(posedge Clk) begin
        if (wr_en) mem[wptr_q] <= DIN;
    end

    always_ff @(posedge Clk or posedge Async_Flush) begin
        if (Async_Flush) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rd_q        <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= (AF_LEVEL == 0);
            ae_q        <= 1'b1;
            push_flag_q <= PUSH_FLAG_RST;
            pop_flag_q  <= 4'd0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rd_q        <= rd_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            push_flag_q <= push_flag_d;
            pop_flag_q  <= pop_flag_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    generate
        if (REG_RD) begin : g_out_reg
            logic [DATA_WIDTH-1:0] dout_q, dout_d;
            always_comb begin
                dout_d = dout_q;
                if (Clk_En) dout_d = flush ? '0 : rd_q;
            end
            always_ff @(posedge Clk or posedge Async_Flush) begin
                if (Async_Flush) dout_q <= '0;
                else             dout_q <= dout_d;
            end
            assign DOUT = dout_q;
        end else begin : g_no_out_reg
            assign DOUT = rd_q;
        end
    endgenerate

    assign Full         = full_q;
    assign Empty        = empty_q;
    assign Almost_Full  = af_q;
    assign Almost_Empty = ae_q;
    assign PUSH_FLAG    = push_flag_q;
    assign POP_FLAG     = pop_flag_q;
    assign Count        = count_q;
    assign Overflow     = ovf_q;
    assign Underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised bench for fifo_sync_param against a queue-based reference model.
module tb_fifo_sync_param;

    localparam int DW     = 8;
    localparam int AW     = 9;
    localparam int DEPTH  = 1 << AW;
    localparam int AF     = DEPTH - 4;
    localparam int AE     = 4;
    localparam bit REG_RD = 1'b0;

    logic          Clk = 1'b0;
    logic          Async_Flush;
    logic          Clk_En;
    logic          Fifo_Push_Flush;
    logic          Fifo_Pop_Flush;
    logic          PUSH;
    logic [DW-1:0] DIN;
    logic          POP;
    logic [DW-1:0] DOUT;
    logic          Full, Empty, Almost_Full, Almost_Empty;
    logic [3:0]    PUSH_FLAG, POP_FLAG;
    logic [AW:0]   Count;
    logic          Overflow, Underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    bit            m_ovf, m_unf;
    logic [DW-1:0] m_d1, m_d2;

    fifo_sync_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .REG_RD(REG_RD)
    ) dut (
        .Clk(Clk), .Async_Flush(Async_Flush), .Clk_En(Clk_En),
        .Fifo_Push_Flush(Fifo_Push_Flush), .Fifo_Pop_Flush(Fifo_Pop_Flush),
        .PUSH(PUSH), .DIN(DIN), .POP(POP), .DOUT(DOUT),
        .Full(Full), .Empty(Empty), .Almost_Full(Almost_Full), .Almost_Empty(Almost_Empty),
        .PUSH_FLAG(PUSH_FLAG), .POP_FLAG(POP_FLAG), .Count(Count),
        .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int code(input int n);
        int c = 0;
        int v = n;
        while (v > 0) begin
            c++;
            v = v / 2;
        end
        return c;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf = 0;
        m_unf = 0;
        m_d1  = '0;
        m_d2  = '0;
    endtask

    task automatic model_edge(input bit en, input bit fl, input bit push, input bit pop,
                              input logic [DW-1:0] din);
        bit was_full, was_empty;
        if (!en) return;
        if (fl) begin
            model_reset();
            return;
        end
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        m_d2 = m_d1;
        if (pop && !was_empty) m_d1 = mq.pop_front();
        if (pop && was_empty)  m_unf = 1;
        if (push && was_full)  m_ovf = 1;
        if (push && !was_full) mq.push_back(din);
    endtask

    task automatic compare_all();
        int n = mq.size();
        check("count",     Count,        n);
        check("empty",     Empty,        n == 0);
        check("full",      Full,         n == DEPTH);
        check("alm_full",  Almost_Full,  n >= AF);
        check("alm_empty", Almost_Empty, n <= AE);
        check("pop_flag",  POP_FLAG,     code(n));
        check("push_flag", PUSH_FLAG,    code(DEPTH - n));
        check("overflow",  Overflow,     m_ovf);
        check("underflow", Underflow,    m_unf);
        check("dout",      DOUT,         REG_RD ? m_d2 : m_d1);
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare
    task automatic step(input bit en, input bit fpush, input bit fpop,
                        input bit push, input bit pop, input logic [DW-1:0] din);
        Clk_En = en; Fifo_Push_Flush = fpush; Fifo_Pop_Flush = fpop;
        PUSH = push; POP = pop; DIN = din;
        @(posedge Clk);
        model_edge(en, fpush | fpop, push, pop, din);
        #1;
        compare_all();
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 1, 0, DW'($urandom));
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 1, DW'($urandom));
    endtask

    initial begin
        Async_Flush = 1'b1; Clk_En = 1'b0; Fifo_Push_Flush = 1'b0; Fifo_Pop_Flush = 1'b0;
        PUSH = 1'b0; POP = 1'b0; DIN = '0;
        model_reset();
        #1;
        compare_all();
        check("rst_push_flag", PUSH_FLAG, 10);
        check("rst_dout", DOUT, 0);
        @(posedge Clk); #1;
        Async_Flush = 1'b0;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 8'h00);
        $display("reset/idle done checks=%0d", checks);

        for (int i = 1; i <= 5; i++) step(1, 0, 0, 1, 0, DW'(i));
        check("pop_flag_after_5", POP_FLAG, 3);
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 0, 0, 1, 8'h00);
            check("ordered_dout", DOUT, i);
        end
        $display("push5/pop5 done checks=%0d", checks);

        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 0, 1, 0, DW'($urandom));
            if (i == AF - 2) check("af_below_level", Almost_Full, 0);
            if (i == AF - 1) check("af_at_level", Almost_Full, 1);
        end
        check("full_at_depth", Full, 1);
        check("push_flag_full", PUSH_FLAG, 0);
        step(1, 0, 0, 1, 0, 8'hAA);
        check("overflow_set", Overflow, 1);
        check("count_stays_full", Count, DEPTH);
        step(1, 0, 0, 1, 1, 8'h55);
        check("count_full_pushpop", Count, DEPTH - 1);
        $display("fill/overflow done checks=%0d", checks);

        pop_n(DEPTH - 1);
        step(1, 0, 0, 0, 1, 8'h00);
        check("underflow_set", Underflow, 1);
        step(1, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 1, 1, 8'h3C);
        check("empty_pushpop_count", Count, 1);
        check("empty_pushpop_unf", Underflow, 1);
        $display("underflow done checks=%0d", checks);

        step(1, 0, 1, 0, 0, 8'h00);
        for (int r = 0; r < 2; r++) begin
            push_n(300);
            pop_n(300);
        end
        $display("wrap 2x300 done checks=%0d", checks);

        push_n(37);
        step(1, 0, 0, 1, 1, 8'h00);
        step(1, 0, 1, 1, 0, 8'h77);
        check("flush_count", Count, 0);
        check("flush_empty", Empty, 1);
        $display("flush done checks=%0d", checks);

        push_n(6);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, DW'($urandom));
        check("clk_en_hold", Count, 6);
        $display("clk_en hold done checks=%0d", checks);

        for (int i = 0; i < 3000; i++) begin
            int pp = (i % 1000 < 500) ? 75 : 25;
            step($urandom_range(99) < 90, $urandom_range(299) == 0, $urandom_range(299) == 0,
                 $urandom_range(99) < pp, $urandom_range(99) < (100 - pp), DW'($urandom));
        end
        $display("random traffic done checks=%0d", checks);

        push_n(20);
        pop_n(3);
        #2;
        Async_Flush = 1'b1;
        model_reset();
        #1;
        compare_all();
        check("async_count", Count, 0);
        #1;
        Async_Flush = 1'b0;
        step(1, 0, 0, 1, 0, 8'h9A);
        $display("async reset done checks=%0d", checks);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
